// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, song entry
// layout, FSM state encoding and the note-to-button decoder.
package melody_pkg;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_D4   = 4'd2;
   localparam logic [3:0] NOTE_E4   = 4'd3;
   localparam logic [3:0] NOTE_F4   = 4'd4;
   localparam logic [3:0] NOTE_G4   = 4'd5;
   localparam logic [3:0] NOTE_A4   = 4'd6;
   localparam logic [3:0] NOTE_B4   = 4'd7;
   localparam logic [3:0] NOTE_C5   = 4'd8;
   localparam logic [3:0] NOTE_END  = 4'd15;

   typedef struct packed {
      logic [3:0] note;
      logic [1:0] dur;
   } entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP,
      ST_DONE
   } state_t;

   // Codes 9..14 fall through to silence, same as an explicit rest.
   function automatic logic [7:0] note2onehot(input logic [3:0] note);
      logic [7:0] oh;
      oh = 8'h00;
      case (note)
         NOTE_C4: oh = 8'h01;
         NOTE_D4: oh = 8'h02;
         NOTE_E4: oh = 8'h04;
         NOTE_F4: oh = 8'h08;
         NOTE_G4: oh = 8'h10;
         NOTE_A4: oh = 8'h20;
         NOTE_B4: oh = 8'h40;
         NOTE_C5: oh = 8'h80;
         default: oh = 8'h00;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/melody_sequencer_rom.sv
// Fixed song table; the only place the tune itself is defined.
// Unused slots hold END so a short song stops cleanly.
module melody_rom
   import melody_pkg::*;
(
   input  logic [3:0] addr,
   output entry_t     entry
);

   always_comb begin
      entry = '{note: NOTE_END, dur: 2'd0};
      case (addr)
         4'd0:    entry = '{note: NOTE_C4,   dur: 2'd0};
         4'd1:    entry = '{note: NOTE_REST, dur: 2'd0};
         4'd2:    entry = '{note: NOTE_G4,   dur: 2'd1};
         4'd3:    entry = '{note: NOTE_C5,   dur: 2'd3};
         default: entry = '{note: NOTE_END,  dur: 2'd0};
      endcase
   end

endmodule

// File: rtl/melody_sequencer.sv
// Autonomous tune player driving the piezo note-select lines:
// steps through the song table with a silent gap after every note.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 12_500_000,
   parameter int GAP_CYCLES     = 1_250_000,
   parameter int SONG_LEN       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop_en,
   output logic [7:0] btn_out,
   output logic       busy,
   output logic       done,
   output logic [3:0] note_idx
);

   localparam int CW = $clog2(4 * TICKS_PER_BEAT);
   localparam int IW = 5;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     btn_q, btn_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   entry_t         rom_entry;
   logic           at_end;
   logic [CW-1:0]  play_cnt;

   melody_rom u_rom (
      .addr  (idx_q[3:0]),
      .entry (rom_entry)
   );

   // Index SONG_LEN is one past the table, hence the extra index bit.
   assign at_end = (rom_entry.note == NOTE_END) ||
                   (idx_q == IW'(SONG_LEN));

   assign play_cnt = CW'((int'(rom_entry.dur) + 1) * TICKS_PER_BEAT
                         - GAP_CYCLES - 1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      btn_d   = btn_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (stop) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         btn_d   = 8'h00;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_LOAD;
                  idx_d   = '0;
                  busy_d  = 1'b1;
               end
            end
            ST_LOAD: begin
               // An END at entry 0 finishes even when looping.
               if (at_end) begin
                  if (loop_en && idx_q != '0) begin
                     idx_d = '0;
                  end else begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  btn_d   = note2onehot(rom_entry.note);
                  cnt_d   = play_cnt;
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (cnt_q == '0) begin
                  btn_d   = 8'h00;
                  cnt_d   = CW'(GAP_CYCLES - 1);
                  state_d = ST_GAP;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            ST_GAP: begin
               if (cnt_q == '0) begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ST_LOAD;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         btn_q   <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign btn_out  = btn_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign note_idx = idx_q[3:0];

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICKS_PER_BEAT=10, GAP_CYCLES=2.
module tb_melody_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       loop_en;
   logic [7:0] btn_out;
   logic       busy;
   logic       done;
   logic [3:0] note_idx;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   melody_sequencer #(
      .TICKS_PER_BEAT (10),
      .GAP_CYCLES     (2),
      .SONG_LEN       (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
      .btn_out  (btn_out),
      .busy     (busy),
      .done     (done),
      .note_idx (note_idx)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic skip(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // n consecutive cycles of a fixed button pattern while busy.
   task automatic run(input string tag, input logic [7:0] btn, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, btn_out, btn);
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_done"}, done, 1'b0);
         step();
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;
      step();
      step();
      chk("rst_btn", btn_out, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_idx", note_idx, 4'd0);
      rst = 1'b0;
      step();
   endtask

   // Start pulse; returns at the first cycle the C4 output is visible.
   task automatic begin_song(input logic lp);
      loop_en = lp;
      start   = 1'b1;
      step();
      chk("load_btn", btn_out, 8'h00);
      chk("load_busy", busy, 1'b1);
      chk("load_idx", note_idx, 4'd0);
      start = 1'b0;
      step();
   endtask

   task automatic play_song(input logic lp, input logic inj);
      begin_song(lp);
      run("c4", 8'h01, 8);
      run("gap_c4_rest", 8'h00, 14);
      start = inj;
      run("g4", 8'h10, 18);
      start = 1'b0;
      run("gap_g4", 8'h00, 3);
      run("c5", 8'h80, 38);
      run("gap_c5", 8'h00, 2);
      chk("end_load_idx", note_idx, 4'd4);
      chk("end_load_busy", busy, 1'b1);
      chk("end_load_done", done, 1'b0);
      step();
      if (!lp) begin
         chk("done_pulse", done, 1'b1);
         chk("done_busy", busy, 1'b0);
         chk("done_idx", note_idx, 4'd4);
         chk("done_btn", btn_out, 8'h00);
         step();
         chk("after_done", done, 1'b0);
         chk("after_busy", busy, 1'b0);
      end else begin
         chk("wrap_done", done, 1'b0);
         chk("wrap_busy", busy, 1'b1);
         chk("wrap_idx", note_idx, 4'd0);
         chk("wrap_btn", btn_out, 8'h00);
         step();
         chk("wrap_c4", btn_out, 8'h01);
         chk("wrap_c4_busy", busy, 1'b1);
         chk("wrap_c4_done", done, 1'b0);
      end
   endtask

   initial begin
      int done_seen;

      do_reset();
      play_song(1'b0, 1'b0);

      do_reset();
      play_song(1'b1, 1'b0);

      do_reset();
      begin_song(1'b0);
      skip(8 + 14 + 5);
      chk("mid_g4", btn_out, 8'h10);
      stop = 1'b1;
      step();
      chk("stop_btn", btn_out, 8'h00);
      chk("stop_busy", busy, 1'b0);
      chk("stop_idx", note_idx, 4'd0);
      chk("stop_done", done, 1'b0);
      start = 1'b1;
      step();
      chk("ss_busy", busy, 1'b0);
      chk("ss_btn", btn_out, 8'h00);
      step();
      chk("ss_busy2", busy, 1'b0);
      chk("ss_done", done, 1'b0);
      start = 1'b0;
      stop  = 1'b0;
      step();

      do_reset();
      begin_song(1'b0);
      skip(8 + 14 + 18 + 3 + 10);
      chk("mid_c5", btn_out, 8'h80);
      #2 rst = 1'b1;
      #1;
      chk("async_btn", btn_out, 8'h00);
      chk("async_busy", busy, 1'b0);
      chk("async_idx", note_idx, 4'd0);
      step();
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) done_seen++;
         step();
      end
      chk("no_done_after_rst", done_seen, 0);
      chk("idle_after_rst", busy, 1'b0);

      do_reset();
      play_song(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
